pc_fetch_stage: RTL
===================

Name: pc_fetch_stage

Overview:
- Program-counter register stage that sits directly downstream of the 32-bit two-to-one next-PC MUX.
- Produces the sequential address pc_plus4, which drives MUX input A. The datapath drives the branch/jump target on MUX input B.
- Registers the MUX output as the new PC whenever the instruction-fetch handshake completes.
- Adds stall, halt and misaligned-target fault handling through a small state machine.

Parameters:
- WIDTH, 32, address width of pc, next_pc and pc_plus4.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INCR, 4, sequential increment added to pc to form pc_plus4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- next_pc  input  WIDTH  selected next address, driven by the two-to-one MUX output.
- stall  input  1  pipeline hazard hold; blocks acceptance while high.
- halt  input  1  stop request, sampled only on an accepted fetch.
- fetch_ready  input  1  instruction memory can take the address this cycle.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus4  output  WIDTH  pc + INCR (combinational); feeds MUX input A.
- fetch_valid  output  1  pc is a valid fetch request.
- halted  output  1  sticky; stage has stopped on halt.
- fault  output  1  sticky; misaligned next_pc was seen.
- fault_addr  output  WIDTH  the offending next_pc value, captured on fault.

Behaviour:
- Reset (asynchronous, effective immediately while high):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, halted=0, fault=0, fault_addr=0.
- States: BOOT, FETCH, HALTED, FAULT; encoded in 2 bits.
- BOOT:
  - fetch_valid=0.
  - Moves to FETCH on the first clock edge after reset deasserts, unconditionally.
- FETCH:
  - fetch_valid=1.
  - accept = fetch_valid & fetch_ready & ~stall.
- On accept, evaluated in priority order:
  1. halt=1 -> state HALTED; pc holds its value; halted=1 from the next cycle.
  2. next_pc[1:0]!=2'b00 -> state FAULT; fault=1; fault_addr<=next_pc; pc holds.
  3. Otherwise pc<=next_pc (one-cycle latency from accept to the new pc).
- No accept (stall=1 or fetch_ready=0):
  - pc, pc_plus4 and fetch_valid hold stable.
  - Request stays asserted until it is accepted.
- HALTED and FAULT:
  - Terminal; only reset exits them.
  - fetch_valid=0; pc frozen; halt, stall and fetch_ready are ignored.
- pc_plus4 arithmetic:
  - Computed modulo 2^WIDTH; wraps to 0 past the top of the address space (e.g. 32'hFFFF_FFFC + 4 = 0). No carry out.
- Simultaneous events:
  - stall=1 together with halt=1 -> no accept, so halt is ignored that cycle.
  - halt=1 with a misaligned next_pc -> HALTED wins; fault stays 0.
- Reset asserted mid-fetch or mid-stall:
  - pc returns to RESET_VECTOR immediately (asynchronous).
  - fetch_valid drops to 0 in the same cycle.
  - Any pending request is discarded.
- next_pc is sampled only on accept; its value in other cycles is don't-care.

Optional Feature:
- Macro: PC_FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count [31:0]: increments by 1 on every accept that loads pc (case 3 only).
  - Reset value 0; wraps from 32'hFFFF_FFFF to 0.
  - Holds its value in HALTED and FAULT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset sequencing: reset=1 then released, next_pc=pc_plus4, fetch_ready=1 -> fetch_valid=0 in the BOOT cycle; pc then runs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Stall hold: stall=1 for 3 cycles at pc=0x8 -> pc=0x8, pc_plus4=0xC and fetch_valid=1 throughout; pc=0xC one cycle after stall drops. Repeat with fetch_ready=0 -> same response.
- Branch redirect: next_pc=0x0000_0010 on an accept at pc=0x4 -> pc=0x10 next cycle, pc_plus4=0x14.
- Misaligned target: next_pc=0x0000_0002 accepted -> fault=1, fault_addr=0x2, pc holds 0x4, fetch_valid=0. Fault is sticky until reset.
- Halt priority: halt=1 and next_pc=0x3 in the same accept -> halted=1, fault=0, pc unchanged. halt=1 with stall=1 -> no halt taken.
- Wrap and async reset: RESET_VECTOR=32'hFFFF_FFFC -> pc_plus4=0, next pc=0. Assert reset between clock edges -> pc=0xFFFF_FFFC at once. With PC_FETCH_COUNT_EN, fetch_count=0 after reset and equals the number of accepted loads.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program-counter register stage: holds the fetch address, presents pc+INCR to the
// next-PC mux, and stops on halt or a misaligned target. Optional PC_FETCH_COUNT_EN.
module pc_fetch_stage #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCR         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             stall,
  input  logic             halt,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             fault,
  output logic [WIDTH-1:0] fault_addr
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HALTED, FAULT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic             accept;
  logic             load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Halt outranks the alignment check; neither is looked at unless the fetch is taken.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    load         = 1'b0;
    accept       = (state_q == FETCH) && fetch_ready && !stall;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          if (halt) begin
            state_d = HALTED;
          end else if (next_pc[1:0] != 2'b00) begin
            state_d      = FAULT;
            fault_addr_d = next_pc;
          end else begin
            pc_d = next_pc;
            load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + WIDTH'(INCR);
  assign fetch_valid = (state_q == FETCH);
  assign halted      = (state_q == HALTED);
  assign fault       = (state_q == FAULT);
  assign fault_addr  = fault_addr_q;

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_count = cnt_q;
`endif

endmodule
